// File: rtl/conv_gauss_pkg.sv
// Shared widths and pixel/word types for the 1x3 Gaussian smoothing stage.
package conv_gauss_pkg;

  localparam int unsigned PIXEL_WIDTH     = 8;
  localparam int unsigned PIXELS_PER_WORD = 16;
  localparam int unsigned WORD_WIDTH      = PIXEL_WIDTH * PIXELS_PER_WORD;

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;
  typedef logic [WORD_WIDTH-1:0]  word_t;

endpackage

// File: rtl/conv_gauss_if.sv
// Data path bundle between the stream producer and the smoothing stage.
interface conv_gauss_if;
  import conv_gauss_pkg::*;

  logic  stall;
  word_t din;
  word_t dout;

  modport master (
    output stall,
    output din,
    input  dout
  );

  modport slave (
    input  stall,
    input  din,
    output dout
  );

endinterface

// File: rtl/gauss3_px.sv
// Single-pixel [1 2 1]/4 kernel with round-half-up; the result always fits in 8 bits.
module gauss3_px
  import conv_gauss_pkg::*;
(
  input  pixel_t l_i,
  input  pixel_t c_i,
  input  pixel_t r_i,
  output pixel_t y_o
);

  logic [PIXEL_WIDTH+1:0] sum;
  logic [1:0]             unused_frac;

  assign sum = {2'b00, l_i} + {1'b0, c_i, 1'b0} + {2'b00, r_i} + (PIXEL_WIDTH+2)'(2);
  assign {y_o, unused_frac} = sum;

endmodule

// File: rtl/conv_gauss.sv
// Streaming 1x3 horizontal Gaussian filter over 16-pixel words, two-beat latency,
// single stall input that freezes every register.
module conv_gauss
  import conv_gauss_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH = 512
) (
  input logic         aclk,
  input logic         aresetn,
  conv_gauss_if.slave bus
);

  localparam int unsigned WORDS_PER_ROW = IMAGE_WIDTH / PIXELS_PER_WORD;
  localparam int unsigned ColW = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam logic [ColW-1:0] LastCol = ColW'(WORDS_PER_ROW - 1);

  word_t          cur_q;
  pixel_t         pl_q;
  logic [ColW-1:0] col_q, col_d;
  logic [ColW-1:0] cur_col;
  word_t          dout_q, dout_d;

  pixel_t ctr_px   [PIXELS_PER_WORD];
  pixel_t left_px  [PIXELS_PER_WORD];
  pixel_t right_px [PIXELS_PER_WORD];

  // col_q counts the column of the next incoming word; cur sits one column behind.
  // After reset col_q=0, so the first real word lands in column 0.
  always_comb begin
    col_d   = (col_q == LastCol) ? '0 : col_q + ColW'(1);
    cur_col = (col_q == '0) ? LastCol : col_q - ColW'(1);
  end

  // Gather the three taps per pixel, replicating at row edges.
  always_comb begin
    for (int j = 0; j < PIXELS_PER_WORD; j++) begin
      ctr_px[j] = cur_q[j*PIXEL_WIDTH +: PIXEL_WIDTH];
    end
    for (int j = 1; j < PIXELS_PER_WORD; j++) begin
      left_px[j] = ctr_px[j-1];
    end
    left_px[0] = (cur_col == '0) ? ctr_px[0] : pl_q;
    for (int j = 0; j < PIXELS_PER_WORD - 1; j++) begin
      right_px[j] = ctr_px[j+1];
    end
    right_px[PIXELS_PER_WORD-1] = (cur_col == LastCol) ? ctr_px[PIXELS_PER_WORD-1]
                                                       : bus.din[PIXEL_WIDTH-1:0];
  end

  for (genvar g = 0; g < PIXELS_PER_WORD; g++) begin : g_px
    gauss3_px u_px (
      .l_i (left_px[g]),
      .c_i (ctr_px[g]),
      .r_i (right_px[g]),
      .y_o (dout_d[g*PIXEL_WIDTH +: PIXEL_WIDTH])
    );
  end

  // Pipeline registers: reset beats stall, stall freezes everything.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cur_q  <= '0;
      pl_q   <= '0;
      col_q  <= '0;
      dout_q <= '0;
    end else if (!bus.stall) begin
      cur_q  <= bus.din;
      pl_q   <= cur_q[WORD_WIDTH-1 -: PIXEL_WIDTH];
      col_q  <= col_d;
      dout_q <= dout_d;
    end
  end

  assign bus.dout = dout_q;

endmodule

// File: tb/tb_conv_gauss.sv
// Directed vector bench for conv_gauss: one record per clock edge, optional check of dout.
module tb_conv_gauss;
  import conv_gauss_pkg::*;

  logic aclk;
  logic aresetn;

  conv_gauss_if u_bus ();

  conv_gauss #(
    .IMAGE_WIDTH (512)
  ) u_dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (u_bus.slave)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic   rstn;
    logic   stall;
    word_t  din;
    logic   chk;
    word_t  exp;
    string  name;
  } vec_t;

  vec_t vq[$];
  int   n_applied;
  int   n_miscmp;
  logic done;

  function automatic word_t px(int j, logic [7:0] v);
    word_t w;
    w = '0;
    w[8*j +: 8] = v;
    return w;
  endfunction

  function automatic word_t fill(logic [7:0] v);
    word_t w;
    for (int j = 0; j < 16; j++) w[8*j +: 8] = v;
    return w;
  endfunction

  task automatic add(input logic rstn, input logic stall, input word_t din,
                     input logic chk, input word_t exp, input string name);
    vec_t v;
    v.rstn = rstn; v.stall = stall; v.din = din; v.chk = chk; v.exp = exp; v.name = name;
    vq.push_back(v);
  endtask

  initial begin
    done = 1'b0;
    fork
      wait (done === 1'b1);
      begin
        repeat (2000) @(posedge aclk);
      end
    join_any
    disable fork;
    if (done !== 1'b1) begin
      n_miscmp++;
      $display("FAIL timeout: bench did not complete within 2000 cycles");
      $finish;
    end
  end

  initial begin
    word_t z;
    word_t imp_a, imp_b, filt_a, filt_b;
    z = '0;
    n_applied = 0;
    n_miscmp  = 0;

    aresetn     = 1'b0;
    u_bus.stall = 1'b1;
    u_bus.din   = fill(8'hff);
    @(posedge aclk);
    #1;
    n_applied++;
    if (u_bus.dout !== '0) begin
      n_miscmp++;
      $display("FAIL reset_state: dout=%h expected 0", u_bus.dout);
    end

    // Reset state
    add(1'b0, 1'b0, fill(8'hff), 1'b1, z, "reset");

    // Constant image: first result is filter of cleared cur
    add(1'b1, 1'b0, fill(8'h80), 1'b1, z, "const_first");
    add(1'b1, 1'b0, fill(8'h80), 1'b1, fill(8'h80), "const_1");
    add(1'b1, 1'b0, fill(8'h80), 1'b1, fill(8'h80), "const_2");
    add(1'b1, 1'b0, fill(8'h80), 1'b1, fill(8'h80), "const_3");

    // Impulse in pixel 5
    add(1'b0, 1'b0, z, 1'b1, z, "reset_imp");
    add(1'b1, 1'b0, px(5, 8'h40), 1'b1, z, "imp_lat");
    add(1'b1, 1'b0, z, 1'b1, px(4, 8'h10) | px(5, 8'h20) | px(6, 8'h10), "imp_res");
    add(1'b1, 1'b0, z, 1'b1, z, "imp_tail");

    // Impulse at pixel 15 crossing into the next word
    add(1'b0, 1'b0, z, 1'b1, z, "reset_xw");
    add(1'b1, 1'b0, px(15, 8'h40), 1'b1, z, "xw_lat");
    add(1'b1, 1'b0, z, 1'b1, px(14, 8'h10) | px(15, 8'h20), "xw_w0");
    add(1'b1, 1'b0, z, 1'b1, px(0, 8'h10), "xw_w1");
    add(1'b1, 1'b0, z, 1'b1, z, "xw_tail");

    // Row edge: columns 0..30 zero, column 31 has pixel 15, next row starts with 0xfc
    add(1'b0, 1'b0, z, 1'b1, z, "reset_edge");
    for (int k = 0; k < 31; k++) add(1'b1, 1'b0, z, 1'b0, z, "edge_fill");
    add(1'b1, 1'b0, px(15, 8'h40), 1'b1, z, "edge_c30");
    add(1'b1, 1'b0, px(0, 8'hfc), 1'b1, px(14, 8'h10) | px(15, 8'h30), "edge_c31");
    add(1'b1, 1'b0, z, 1'b1, px(0, 8'hbd) | px(1, 8'h3f), "edge_next_row");
    add(1'b1, 1'b0, z, 1'b1, z, "edge_tail");

    // Stall mid-stream with garbage on din; reset wins over stall
    imp_a  = px(3, 8'h40);
    imp_b  = px(10, 8'h80);
    filt_a = px(2, 8'h10) | px(3, 8'h20) | px(4, 8'h10);
    filt_b = px(9, 8'h20) | px(10, 8'h40) | px(11, 8'h20);
    add(1'b1, 1'b0, fill(8'h55), 1'b0, z, "pre_stall");
    add(1'b1, 1'b0, fill(8'h55), 1'b0, z, "pre_stall");
    add(1'b0, 1'b1, fill(8'h55), 1'b1, z, "reset_over_stall");
    add(1'b1, 1'b0, imp_a, 1'b1, z, "stall_lat");
    add(1'b1, 1'b0, imp_b, 1'b1, filt_a, "stall_a");
    for (int k = 0; k < 5; k++) add(1'b1, 1'b1, fill(8'hff), 1'b1, filt_a, "stall_hold");
    add(1'b1, 1'b0, z, 1'b1, filt_b, "stall_b");
    add(1'b1, 1'b0, z, 1'b1, z, "stall_tail");

    // Reset mid-row at column 10, then impulse at pixel 0 must see left replicate
    for (int k = 0; k < 10; k++) add(1'b1, 1'b0, fill(8'h80), 1'b0, z, "mid_fill");
    add(1'b0, 1'b0, fill(8'h80), 1'b1, z, "reset_mid");
    add(1'b1, 1'b0, px(0, 8'h40), 1'b1, z, "mid_lat");
    add(1'b1, 1'b0, z, 1'b1, px(0, 8'h30) | px(1, 8'h10), "mid_res");
    add(1'b1, 1'b0, z, 1'b1, z, "mid_tail");

    foreach (vq[i]) begin
      aresetn     = vq[i].rstn;
      u_bus.stall = vq[i].stall;
      u_bus.din   = vq[i].din;
      @(posedge aclk);
      #1;
      if (vq[i].chk) begin
        n_applied++;
        if (u_bus.dout !== vq[i].exp) begin
          n_miscmp++;
          $display("FAIL vec%0d %s: dout=%h expected %h", i, vq[i].name, u_bus.dout,
                   vq[i].exp);
        end
      end
    end

    done = 1'b1;
    if (n_miscmp != 0) begin
      $display("FAIL: %0d miscompares", n_miscmp);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscmp);
    $finish;
  end

endmodule
